// File: rtl/time_scan_display_pkg.sv
// Shared types and constants for the multiplexed HH:MM:SS display.
package time_scan_display_pkg;

  localparam int unsigned NUM_DIGITS   = 6;
  localparam int unsigned SCAN_DIV_MIN = 24;
  localparam int unsigned DIGIT_W      = 3;
  localparam int unsigned PRESC_W      = 16;
  localparam int unsigned BIN_W        = 7;
  localparam int unsigned BCD_W        = 4;
  localparam int unsigned SEG_W        = 7;

  localparam logic [BIN_W-1:0] HOUR_LIM = BIN_W'(24);
  localparam logic [BIN_W-1:0] MIN_LIM  = BIN_W'(60);
  localparam logic [BIN_W-1:0] SEC_LIM  = BIN_W'(60);
  localparam logic [BIN_W-1:0] BCD_BASE = BIN_W'(10);

  // Conversion sequencer states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SNAP   = 3'd1,
    ST_CONV_H = 3'd2,
    ST_CONV_M = 3'd3,
    ST_CONV_S = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

  // Segment patterns, bit0 = a ... bit6 = g
  localparam logic [SEG_W-1:0] SEG_0     = 7'h3F;
  localparam logic [SEG_W-1:0] SEG_1     = 7'h06;
  localparam logic [SEG_W-1:0] SEG_2     = 7'h5B;
  localparam logic [SEG_W-1:0] SEG_3     = 7'h4F;
  localparam logic [SEG_W-1:0] SEG_4     = 7'h66;
  localparam logic [SEG_W-1:0] SEG_5     = 7'h6D;
  localparam logic [SEG_W-1:0] SEG_6     = 7'h7D;
  localparam logic [SEG_W-1:0] SEG_7     = 7'h07;
  localparam logic [SEG_W-1:0] SEG_8     = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_9     = 7'h6F;
  localparam logic [SEG_W-1:0] SEG_DASH  = 7'h40;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

  // One displayed field (two digits) in BCD, dash marks an out-of-range value
  typedef struct packed {
    logic             dash;
    logic [BCD_W-1:0] tens;
    logic [BCD_W-1:0] units;
  } field_t;

  // Everything one frame displays; s_odd drives the colon-style decimal points
  typedef struct packed {
    field_t h;
    field_t m;
    field_t s;
    logic   s_odd;
  } disp_t;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD digit to seven-segment decoder with dash override.
module bcd_to_seg7
  import time_scan_display_pkg::*;
(
  input  logic [BCD_W-1:0] bcd,
  input  logic             dash,
  output logic [SEG_W-1:0] seg_c
);

  // Dash wins; codes above 9 blank the digit
  always_comb begin
    seg_c = SEG_BLANK;
    if (dash) begin
      seg_c = SEG_DASH;
    end else begin
      case (bcd)
        4'd0:    seg_c = SEG_0;
        4'd1:    seg_c = SEG_1;
        4'd2:    seg_c = SEG_2;
        4'd3:    seg_c = SEG_3;
        4'd4:    seg_c = SEG_4;
        4'd5:    seg_c = SEG_5;
        4'd6:    seg_c = SEG_6;
        4'd7:    seg_c = SEG_7;
        4'd8:    seg_c = SEG_8;
        4'd9:    seg_c = SEG_9;
        default: seg_c = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/time_scan_display.sv
// Six-digit scanned HH:MM:SS display with once-per-frame snapshot and
// sequential binary-to-BCD conversion; each frame shows one coherent time.
module time_scan_display
  import time_scan_display_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 1000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [BIN_W-1:0]      H,
  input  logic [BIN_W-1:0]      M,
  input  logic [BIN_W-1:0]      S,
  output logic [SEG_W-1:0]      seg,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  dp
);

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(SCAN_DIV - 1);
  localparam logic [DIGIT_W-1:0] DIGIT_LAST = DIGIT_W'(NUM_DIGITS - 1);

  state_e state_q, state_d;

  logic                  started_q;
  logic [PRESC_W-1:0]    presc_q, presc_d;
  logic [DIGIT_W-1:0]    digit_q, digit_d;
  logic                  commit_c;
  disp_t                 disp_q, disp_d;

  logic [BIN_W-1:0]      snap_h_q, snap_m_q, snap_s_q;
  logic [BIN_W-1:0]      snap_h_d, snap_m_d, snap_s_d;
  logic [BIN_W-1:0]      hw_q, mw_q, sw_q, hw_d, mw_d, sw_d;
  logic [BCD_W-1:0]      ht_q, mt_q, st_q, ht_d, mt_d, st_d;
  logic                  hd_q, md_q, sd_q, hd_d, md_d, sd_d;

  logic [BCD_W-1:0]      sel_bcd_c;
  logic                  sel_dash_c;
  logic [SEG_W-1:0]      seg_nxt_c;
  logic [NUM_DIGITS-1:0] an_nxt_c;
  logic                  dp_nxt_c;

  // Prescaler and digit index; the first edge after reset only lights digit 0
  // so that its first dwell is a full SCAN_DIV cycles long
  always_comb begin
    presc_d  = presc_q;
    digit_d  = digit_q;
    commit_c = 1'b0;
    if (started_q) begin
      if (presc_q == PRESC_LAST) begin
        presc_d = '0;
        if (digit_q == DIGIT_LAST) begin
          digit_d  = '0;
          commit_c = (state_q == ST_IDLE) || (state_q == ST_DONE);
        end else begin
          digit_d = digit_q + 1'b1;
        end
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
  end

  // Display registers load the finished conversion only at the frame boundary
  always_comb begin
    disp_d = disp_q;
    if (commit_c) begin
      disp_d.h.dash  = hd_q;
      disp_d.h.tens  = ht_q;
      disp_d.h.units = hw_q[BCD_W-1:0];
      disp_d.m.dash  = md_q;
      disp_d.m.tens  = mt_q;
      disp_d.m.units = mw_q[BCD_W-1:0];
      disp_d.s.dash  = sd_q;
      disp_d.s.tens  = st_q;
      disp_d.s.units = sw_q[BCD_W-1:0];
      disp_d.s_odd   = snap_s_q[0];
    end
  end

  // Select the BCD digit for the digit about to be enabled
  always_comb begin
    sel_bcd_c  = '0;
    sel_dash_c = 1'b0;
    case (digit_d)
      3'd0: begin sel_bcd_c = disp_d.h.tens;  sel_dash_c = disp_d.h.dash; end
      3'd1: begin sel_bcd_c = disp_d.h.units; sel_dash_c = disp_d.h.dash; end
      3'd2: begin sel_bcd_c = disp_d.m.tens;  sel_dash_c = disp_d.m.dash; end
      3'd3: begin sel_bcd_c = disp_d.m.units; sel_dash_c = disp_d.m.dash; end
      3'd4: begin sel_bcd_c = disp_d.s.tens;  sel_dash_c = disp_d.s.dash; end
      3'd5: begin sel_bcd_c = disp_d.s.units; sel_dash_c = disp_d.s.dash; end
      default: begin sel_bcd_c = '0; sel_dash_c = 1'b0; end
    endcase
  end

  bcd_to_seg7 u_dec (
    .bcd   (sel_bcd_c),
    .dash  (sel_dash_c),
    .seg_c (seg_nxt_c)
  );

  // Anode and decimal point for the digit about to be enabled
  always_comb begin
    an_nxt_c = NUM_DIGITS'(1) << digit_d;
    dp_nxt_c = ((digit_d == 3'd1) || (digit_d == 3'd3)) && !disp_d.s_odd;
  end

  // Conversion sequencer: snapshot at digit 5, then repeated subtract-by-ten
  always_comb begin
    state_d  = state_q;
    snap_h_d = snap_h_q;
    snap_m_d = snap_m_q;
    snap_s_d = snap_s_q;
    hw_d = hw_q; mw_d = mw_q; sw_d = sw_q;
    ht_d = ht_q; mt_d = mt_q; st_d = st_q;
    hd_d = hd_q; md_d = md_q; sd_d = sd_q;
    case (state_q)
      ST_IDLE: begin
        if (started_q && (digit_q == DIGIT_LAST) && (presc_q == '0)) begin
          snap_h_d = H;
          snap_m_d = M;
          snap_s_d = S;
          state_d  = ST_SNAP;
        end
      end
      ST_SNAP: begin
        hd_d = (snap_h_q >= HOUR_LIM);
        md_d = (snap_m_q >= MIN_LIM);
        sd_d = (snap_s_q >= SEC_LIM);
        hw_d = (snap_h_q >= HOUR_LIM) ? '0 : snap_h_q;
        mw_d = (snap_m_q >= MIN_LIM)  ? '0 : snap_m_q;
        sw_d = (snap_s_q >= SEC_LIM)  ? '0 : snap_s_q;
        ht_d = '0;
        mt_d = '0;
        st_d = '0;
        state_d = ST_CONV_H;
      end
      ST_CONV_H: begin
        if (hw_q >= BCD_BASE) begin
          hw_d = hw_q - BCD_BASE;
          ht_d = ht_q + 1'b1;
        end else begin
          state_d = ST_CONV_M;
        end
      end
      ST_CONV_M: begin
        if (mw_q >= BCD_BASE) begin
          mw_d = mw_q - BCD_BASE;
          mt_d = mt_q + 1'b1;
        end else begin
          state_d = ST_CONV_S;
        end
      end
      ST_CONV_S: begin
        if (sw_q >= BCD_BASE) begin
          sw_d = sw_q - BCD_BASE;
          st_d = st_q + 1'b1;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      started_q <= 1'b0;
      presc_q   <= '0;
      digit_q   <= '0;
      disp_q    <= '0;
      snap_h_q  <= '0;
      snap_m_q  <= '0;
      snap_s_q  <= '0;
      hw_q <= '0; mw_q <= '0; sw_q <= '0;
      ht_q <= '0; mt_q <= '0; st_q <= '0;
      hd_q <= 1'b0; md_q <= 1'b0; sd_q <= 1'b0;
      seg <= '0;
      an  <= '0;
      dp  <= 1'b0;
    end else begin
      started_q <= 1'b1;
      presc_q   <= presc_d;
      digit_q   <= digit_d;
      disp_q    <= disp_d;
      snap_h_q  <= snap_h_d;
      snap_m_q  <= snap_m_d;
      snap_s_q  <= snap_s_d;
      hw_q <= hw_d; mw_q <= mw_d; sw_q <= sw_d;
      ht_q <= ht_d; mt_q <= mt_d; st_q <= st_d;
      hd_q <= hd_d; md_q <= md_d; sd_q <= sd_d;
      seg <= seg_nxt_c;
      an  <= an_nxt_c;
      dp  <= dp_nxt_c;
    end
  end

endmodule

// File: tb/tb_time_scan_display.sv
// Self-checking bench: every frame must show the time present on the inputs
// when the previous frame's last digit began.
module tb_time_scan_display;

  localparam int SD = 32;
  localparam logic [6:0] SEGT [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                       7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  logic       clk;
  logic       rst_n;
  logic [6:0] H, M, S;
  logic [6:0] seg;
  logic [5:0] an;
  logic       dp;

  int n_cmp = 0;
  int n_err = 0;
  int exp_h = 0, exp_m = 0, exp_s = 0;

  time_scan_display #(.SCAN_DIV(SD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .H     (H),
    .M     (M),
    .S     (S),
    .seg   (seg),
    .an    (an),
    .dp    (dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Expected segments for digit d of the currently committed time
  function automatic logic [6:0] exp_seg(input int d);
    int v, lim;
    case (d / 2)
      0:       begin v = exp_h; lim = 24; end
      1:       begin v = exp_m; lim = 60; end
      default: begin v = exp_s; lim = 60; end
    endcase
    if (v >= lim) return 7'h40;
    return SEGT[(d % 2 == 0) ? v / 10 : v % 10];
  endfunction

  function automatic logic exp_dp(input int d);
    return ((d == 1) || (d == 3)) && (exp_s % 2 == 0);
  endfunction

  task automatic wait_an(input logic [5:0] tgt);
    int n;
    n = 0;
    while (an !== tgt && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("wait_an", 32'(an), 32'(tgt));
  endtask

  // Check one whole frame cycle by cycle, drive new inputs at its start and
  // optionally change S while digit 2 is lit
  task automatic run_frame(input bit chg, input int chg_s,
                           input int nh, input int nm, input int ns);
    int ph, pm, ps;
    ph = 0; pm = 0; ps = 0;
    wait_an(6'b000001);
    H = 7'(nh); M = 7'(nm); S = 7'(ns);
    for (int d = 0; d < 6; d++) begin
      for (int k = 0; k < SD; k++) begin
        if (d == 5 && k == 0) begin
          ph = int'(H); pm = int'(M); ps = int'(S);
        end
        check($sformatf("an_d%0d_k%0d", d, k), 32'(an), 32'(1 << d));
        check($sformatf("seg_d%0d_k%0d", d, k), 32'(seg), 32'(exp_seg(d)));
        check($sformatf("dp_d%0d_k%0d", d, k), 32'(dp), 32'(exp_dp(d)));
        if (chg && d == 2 && k == 4) S = 7'(chg_s);
        @(negedge clk);
      end
    end
    exp_h = ph; exp_m = pm; exp_s = ps;
  endtask

  // Continuous one-hot and dwell-length monitor
  logic [5:0] prev_an = '0;
  int         dwell = 0;
  always @(negedge clk) begin
    if (!rst_n || an == 6'b0) begin
      prev_an = '0;
      dwell   = 0;
    end else if (an == prev_an) begin
      dwell++;
    end else begin
      if (prev_an != 6'b0) check("dwell", 32'(dwell), 32'(SD));
      check("onehot", 32'($onehot(an)), 32'd1);
      prev_an = an;
      dwell   = 1;
    end
  end

  initial begin
    rst_n = 1'b0;
    H = '0; M = '0; S = '0;
    repeat (3) @(negedge clk);
    check("rst_seg", 32'(seg), 32'h0);
    check("rst_an", 32'(an), 32'h0);
    check("rst_dp", 32'(dp), 32'h0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("rel_an", 32'(an), 32'h01);
    check("rel_seg", 32'(seg), 32'h3F);
    exp_h = 0; exp_m = 0; exp_s = 0;

    // Zero frame, then 23:59:58, then mid-frame S change, then a dashed minute
    run_frame(1'b0, 0, 23, 59, 58);
    run_frame(1'b1, 59, 23, 59, 58);
    run_frame(1'b0, 0, 12, 75, 34);
    run_frame(1'b0, 0, 0, 0, 0);

    // Random times, occasionally out of range
    for (int i = 0; i < 8; i++) begin
      run_frame(1'b0, 0, int'($urandom_range(0, 27)),
                int'($urandom_range(0, 70)), int'($urandom_range(0, 65)));
    end
    run_frame(1'b0, 0, 23, 59, 58);

    // Abort a conversion in progress: reset while minutes are being converted
    wait_an(6'b000001);
    H = 7'd23; M = 7'd59; S = 7'd58;
    wait_an(6'b100000);
    repeat (7) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_seg", 32'(seg), 32'h0);
    check("abort_an", 32'(an), 32'h0);
    check("abort_dp", 32'(dp), 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_seg", 32'(seg), 32'h0);
      check("hold_an", 32'(an), 32'h0);
    end
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("rel2_an", 32'(an), 32'h01);
    check("rel2_seg", 32'(seg), 32'h3F);
    exp_h = 0; exp_m = 0; exp_s = 0;
    run_frame(1'b0, 0, 23, 59, 58);
    run_frame(1'b0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/time_scan_display.md
TIME_SCAN_DISPLAY -- requirements
Module: time_scan_display

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 1000: clock cycles each digit is enabled; legal range 24..65535.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port H  input  7  binary hours from the time counter; legal 0..23.
REQ-005 SHALL have port M  input  7  binary minutes; legal 0..59.
REQ-006 SHALL have port S  input  7  binary seconds; legal 0..59.
REQ-007 SHALL have port seg  output  7  active-high segments, bit0=a ... bit6=g.
REQ-008 SHALL have port an  output  6  one-hot active-high digit enable; bit0=hours tens (leftmost) ... bit5=seconds units.
REQ-009 SHALL have port dp  output  1  active-high decimal point for the enabled digit.

Function
REQ-010 SHALL scan digits 0,1,2,3,4,5,0,... holding each for exactly SCAN_DIV cycles via a prescaler; one full pass is a frame.
REQ-011 SHALL drive seg and an from registers, changing both in the same cycle; an always exactly one-hot outside reset.
REQ-012 SHALL sample H, M, S into a snapshot on the first cycle of digit 5 in every frame; inputs are otherwise ignored.
REQ-013 SHALL convert the snapshot to BCD sequentially via FSM IDLE -> SNAP -> CONV_H -> CONV_M -> CONV_S -> DONE -> IDLE.
REQ-014 CONV states SHALL subtract 10 once per cycle while value >= 10, incrementing tens, then advance; worst-case total latency 20 cycles (< SCAN_DIV minimum).
REQ-015 SHALL commit converted BCD to display registers only on the digit-5 -> digit-0 transition, so every frame shows one coherent time.
REQ-016 Out-of-range field (H >= 24, M >= 60, S >= 60) SHALL display as two dashes (seg = 7'b1000000) for that field only; other fields unaffected.
REQ-017 SHALL decode BCD 0..9 to standard segments (0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F).
REQ-018 dp SHALL be 1 while digit 1 or digit 3 is enabled and the committed seconds value is even; otherwise 0.
REQ-019 Input changes during CONV states SHALL not affect the conversion in progress.
REQ-020 If the FSM is not in DONE/IDLE at the frame boundary (impossible for legal SCAN_DIV), the previous display registers SHALL be retained.

Reset
REQ-021 While rst_n = 0: seg = 0, an = 0, dp = 0, prescaler = 0, digit index = 0, FSM = IDLE, snapshot and display registers = 0.
REQ-022 On the first rising edge after rst_n rises: an = 6'b000001, seg = 0x3F (display "00:00:00").
REQ-023 Reset assertion mid-conversion SHALL abort conversion immediately; no partial commit.

Structure
REQ-024 Shared package SHALL hold: FSM state enum, segment constants (digits 0-9, dash, blank), NUM_DIGITS = 6, minimum SCAN_DIV.
REQ-025 SHALL instantiate one combinational sub-module bcd_to_seg7 (4-bit BCD plus dash flag -> 7 segments); everything else lives in time_scan_display.

Verification (SCAN_DIV = 32)
REQ-026 Reset release, H=0 M=0 S=0 -> an cycles 000001..100000, 32 cycles each; seg 0x3F on every digit; dp on digits 1 and 3.
REQ-027 H=23 M=59 S=58 before a frame -> next frame seg: 0x5B,0x4F,0x6D,0x6F,0x6D,0x7F; dp on digits 1 and 3.
REQ-028 S changes 58 -> 59 mid-frame at digit 2 -> current frame unchanged; next frame digit 5 = 0x6F, dp = 0.
REQ-029 M=75, H=12, S=34 -> digits 2,3 = 0x40; digits 0,1,4,5 = 0x06,0x5B,0x4F,0x66.
REQ-030 rst_n pulsed low 3 cycles during CONV_M -> outputs zero during pulse; next edge after release an=000001, seg=0x3F; no stale digits.
REQ-031 Check continuously: an one-hot, dwell exactly SCAN_DIV cycles, no seg change within a dwell.
